// File: rtl/mult_seq_16b.sv
// mult_seq_16b -- sequential 16x16 shift-and-add multiplier, 32-bit product.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   start    request; accepted in IDLE (and in DONE, for back-to-back issue)
//   sgn      1 = signed two's-complement operands, 0 = unsigned
//   a, b     16-bit multiplicand / multiplier, latched with start
//   busy     high whenever the state is not IDLE
//   done     single-cycle pulse while the new product is valid
//   product  32-bit result register, changes only on the FIX edge
//   hi, lo   product[31:16] / product[15:0]
//
// All 32-bit arithmetic goes through a single ripple-carry Adder_32b whose
// operands are muxed between accumulate (RUN) and negate (FIX).

module Adder_32b (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);

  logic [32:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 32; i++) begin
      Sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    Cout = c[32];
  end

endmodule

module mult_seq_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] hi,
  output logic [15:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic [4:0]  cnt;
  logic        neg;
  logic [31:0] product_r;

  logic [31:0] add_x, add_y, add_sum;
  logic        add_cin;
  logic        adder_cout_unused;
  logic [31:0] mcand_sh;

  logic [15:0] a_mag, b_mag;
  logic        load;

  // Magnitudes for signed mode; 0x8000 maps onto itself, which is the
  // correct unsigned magnitude 32768.
  assign a_mag = (sgn && a[15]) ? (~a + 16'd1) : a;
  assign b_mag = (sgn && b[15]) ? (~b + 16'd1) : b;

  // DONE accepts a new start so the next operation can be sampled on the
  // edge that leaves DONE (18-cycle throughput).
  assign load = start && ((state == IDLE) || (state == DONE));

  assign mcand_sh = {16'b0, mcand} << cnt;

  always_comb begin
    add_x   = acc;
    add_y   = mcand_sh;
    add_cin = 1'b0;
    if (state == FIX) begin
      add_x   = ~acc;
      add_y   = '0;
      add_cin = 1'b1;
    end
  end

  Adder_32b u_adder (
    .x    (add_x),
    .y    (add_y),
    .Cin  (add_cin),
    .Sum  (add_sum),
    .Cout (adder_cout_unused)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == 5'd15) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_r <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mcand <= a_mag;
        mplr  <= b_mag;
        neg   <= sgn & (a[15] ^ b[15]);
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        if (mplr[0]) acc <= add_sum;
        mplr <= mplr >> 1;
        cnt  <= cnt + 5'd1;
      end else if (state == FIX) begin
        product_r <= neg ? add_sum : acc;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign product = product_r;
  assign hi      = product_r[31:16];
  assign lo      = product_r[15:0];

endmodule
